// File: rtl/width_reductor_multi.sv
// Splits a wide word of NO lanes (first 'active' valid) into beats of up to NO_OUT lanes,
// each tagged {last, cnt}, through a registered valid/ready output stage.
module width_reductor_multi #(
  parameter int W_DATA   = 16,
  parameter int NO       = 4,
  parameter int NO_OUT   = 2,
  parameter int W_ACTIVE = 3,
  localparam int W_CNT   = $clog2(NO_OUT + 1),
  localparam int W_IN    = W_ACTIVE + NO * W_DATA,
  localparam int W_OUT   = 1 + W_CNT + NO_OUT * W_DATA
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [W_IN-1:0]  din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [W_OUT-1:0] dout_data
);

  localparam int W_IDX = $clog2(NO) + 1;
  // Arithmetic width wide enough for active, idx and idx+NO_OUT without overflow.
  localparam int W_L   = ((W_ACTIVE > W_IDX) ? W_ACTIVE : W_IDX) + 1;

  logic [W_DATA-1:0]        lane_in [NO];
  logic [W_ACTIVE-1:0]      active;
  logic [W_L-1:0]           eff_l, idx_l, end_l, cnt_l;
  logic                     beat_last, load;
  logic [NO_OUT*W_DATA-1:0] beat_data;

  logic                     dout_valid_q, dout_valid_d;
  logic [W_OUT-1:0]         dout_data_q, dout_data_d;
  logic [W_IDX-1:0]         idx_q, idx_d;

  genvar gi;
  generate
    for (gi = 0; gi < NO; gi++) begin : g_unpack
      assign lane_in[gi] = din_data[gi*W_DATA +: W_DATA];
    end
  endgenerate

  assign active = din_data[W_IN-1 -: W_ACTIVE];

  always_comb begin
    eff_l     = (W_L'(active) > W_L'(NO)) ? W_L'(NO) : W_L'(active);
    idx_l     = W_L'(idx_q);
    end_l     = idx_l + W_L'(NO_OUT);
    beat_last = (end_l >= eff_l);
    cnt_l     = beat_last ? (eff_l - idx_l) : W_L'(NO_OUT);
  end

  // Out lane i takes input lane idx+i when i is within the beat; otherwise zero.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < NO_OUT; i++) begin
      if (W_L'(i) < cnt_l) begin
        for (int j = 0; j < NO; j++) begin
          if (idx_l + W_L'(i) == W_L'(j)) begin
            beat_data[i*W_DATA +: W_DATA] = lane_in[j];
          end
        end
      end
    end
  end

  assign load      = din_valid && (eff_l != '0) && (!dout_valid_q || dout_ready);
  // Held low during reset so the upstream word is not consumed while we discard state.
  assign din_ready = rst_n && ((load && beat_last) || (din_valid && (eff_l == '0)));

  always_comb begin
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    idx_d        = idx_q;
    if (load) begin
      dout_valid_d = 1'b1;
      dout_data_d  = {beat_last, W_CNT'(cnt_l), beat_data};
      idx_d        = beat_last ? '0 : W_IDX'(end_l);
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      idx_q        <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      idx_q        <= idx_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;

endmodule

// File: tb/tb_width_reductor_multi.sv
// Directed bench for width_reductor_multi: NO_OUT=2 main instance plus NO_OUT=1 and 4.
module tb_width_reductor_multi;

  localparam logic [15:0] LA = 16'hA0A0, LB = 16'hB1B1, LC = 16'hC2C2, LD = 16'hD3D3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [66:0] din_data = '0;
  logic        din_valid = 1'b0, dout_ready = 1'b1;
  logic        din_ready, dout_valid;
  logic [34:0] dout_data;
  logic        v1 = 1'b0, dr1, dv1;
  logic [17:0] dd1;
  logic        v4 = 1'b0, dr4, dv4;
  logic [67:0] dd4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  width_reductor_multi #(.W_DATA(16), .NO(4), .NO_OUT(2), .W_ACTIVE(3)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
    .din_data(din_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data));

  width_reductor_multi #(.W_DATA(16), .NO(4), .NO_OUT(1), .W_ACTIVE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(v1), .din_ready(dr1),
    .din_data(din_data), .dout_valid(dv1), .dout_ready(1'b1), .dout_data(dd1));

  width_reductor_multi #(.W_DATA(16), .NO(4), .NO_OUT(4), .W_ACTIVE(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .din_valid(v4), .din_ready(dr4),
    .din_data(din_data), .dout_valid(dv4), .dout_ready(1'b1), .dout_data(dd4));

  function automatic logic [35:0] e2(input logic last, input logic [1:0] c,
                                     input logic [15:0] l1, input logic [15:0] l0);
    return {1'b1, last, c, l1, l0};
  endfunction

  function automatic logic [18:0] e1(input logic last, input logic [15:0] l0);
    return {1'b1, last, 1'b1, l0};
  endfunction

  task automatic set_word(input logic [2:0] act, input logic [15:0] d, input logic [15:0] c,
                          input logic [15:0] b, input logic [15:0] a);
    din_data = {act, d, c, b, a};
  endtask

  task automatic test_reset;
    logic [35:0] exp;
    rst_n = 1'b0; set_word(3'd3, LD, LC, LB, LA); din_valid = 1'b1; v1 = 1'b1; v4 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    exp = '0;
    n_vec++; if ({dout_valid, dout_data} !== exp) begin n_err++;
      $display("FAIL rst_out got=%h exp=%h", {dout_valid, dout_data}, exp); end
    n_vec++; if ({din_ready, dr1, dr4} !== 3'b000) begin n_err++;
      $display("FAIL rst_din_ready got=%b exp=000", {din_ready, dr1, dr4}); end
    n_vec++; if ({dv1, dv4} !== 2'b00) begin n_err++;
      $display("FAIL rst_valid_others got=%b exp=00", {dv1, dv4}); end
    din_valid = 1'b0; v1 = 1'b0; v4 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (dout_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_release_valid got=%b exp=0", dout_valid); end
  endtask

  task automatic test_basic;
    @(negedge clk); set_word(3'd3, LD, LC, LB, LA); din_valid = 1'b1; dout_ready = 1'b1; #1;
    n_vec++; if (din_ready !== 1'b0) begin n_err++;
      $display("FAIL t1_rdy_first got=%b exp=0", din_ready); end
    @(negedge clk); #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b0, 2'd2, LB, LA)) begin n_err++;
      $display("FAIL t1_beat0 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b0, 2'd2, LB, LA)); end
    n_vec++; if (din_ready !== 1'b1) begin n_err++;
      $display("FAIL t1_rdy_second got=%b exp=1", din_ready); end
    @(negedge clk); set_word(3'd1, LD, LC, LB, 16'h1234); #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b1, 2'd1, 16'h0, LC)) begin n_err++;
      $display("FAIL t1_beat1 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b1, 2'd1, 16'h0, LC)); end
    n_vec++; if (din_ready !== 1'b1) begin n_err++;
      $display("FAIL t1_next_rdy got=%b exp=1", din_ready); end
    @(negedge clk); din_valid = 1'b0; #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b1, 2'd1, 16'h0, 16'h1234)) begin n_err++;
      $display("FAIL t1_no_bubble got=%h exp=%h", {dout_valid, dout_data},
               e2(1'b1, 2'd1, 16'h0, 16'h1234)); end
    @(negedge clk); #1;
    n_vec++; if (dout_valid !== 1'b0) begin n_err++;
      $display("FAIL t1_drain got=%b exp=0", dout_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk); set_word(3'd4, LD, LC, LB, LA); din_valid = 1'b1; dout_ready = 1'b1; #1;
    n_vec++; if (din_ready !== 1'b0) begin n_err++;
      $display("FAIL t2_rdy_first got=%b exp=0", din_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dout_ready = (i == 3); #1;
      n_vec++; if ({dout_valid, dout_data} !== e2(1'b0, 2'd2, LB, LA)) begin n_err++;
        $display("FAIL t2_hold%0d got=%h exp=%h", i, {dout_valid, dout_data},
                 e2(1'b0, 2'd2, LB, LA)); end
      n_vec++; if (din_ready !== (i == 3)) begin n_err++;
        $display("FAIL t2_rdy%0d got=%b exp=%b", i, din_ready, (i == 3)); end
    end
    @(negedge clk); din_valid = 1'b0; #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b1, 2'd2, LD, LC)) begin n_err++;
      $display("FAIL t2_beat1 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b1, 2'd2, LD, LC)); end
    @(negedge clk); #1;
    n_vec++; if (dout_valid !== 1'b0) begin n_err++;
      $display("FAIL t2_drain got=%b exp=0", dout_valid); end
  endtask

  task automatic test_empty_word;
    @(negedge clk); set_word(3'd0, LD, LC, LB, LA); din_valid = 1'b1; #1;
    n_vec++; if (din_ready !== 1'b1) begin n_err++;
      $display("FAIL t3_drop_rdy got=%b exp=1", din_ready); end
    @(negedge clk); set_word(3'd1, LD, LC, LB, LA); #1;
    n_vec++; if (dout_valid !== 1'b0) begin n_err++;
      $display("FAIL t3_no_beat got=%b exp=0", dout_valid); end
    n_vec++; if (din_ready !== 1'b1) begin n_err++;
      $display("FAIL t3_one_rdy got=%b exp=1", din_ready); end
    @(negedge clk); din_valid = 1'b0; #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b1, 2'd1, 16'h0, LA)) begin n_err++;
      $display("FAIL t3_beat got=%h exp=%h", {dout_valid, dout_data}, e2(1'b1, 2'd1, 16'h0, LA)); end
    @(negedge clk);
  endtask

  task automatic test_clamp;
    @(negedge clk); set_word(3'd7, LD, LC, LB, LA); din_valid = 1'b1; #1;
    n_vec++; if (din_ready !== 1'b0) begin n_err++;
      $display("FAIL t4_rdy_first got=%b exp=0", din_ready); end
    @(negedge clk); #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b0, 2'd2, LB, LA)) begin n_err++;
      $display("FAIL t4_beat0 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b0, 2'd2, LB, LA)); end
    n_vec++; if (din_ready !== 1'b1) begin n_err++;
      $display("FAIL t4_rdy_second got=%b exp=1", din_ready); end
    @(negedge clk); din_valid = 1'b0; #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b1, 2'd2, LD, LC)) begin n_err++;
      $display("FAIL t4_beat1 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b1, 2'd2, LD, LC)); end
    @(negedge clk);
  endtask

  task automatic test_out_widths;
    logic [68:0] exp4;
    exp4 = {1'b1, 1'b1, 3'd3, 16'h0, LC, LB, LA};
    @(negedge clk); set_word(3'd3, LD, LC, LB, LA); v1 = 1'b1; v4 = 1'b1; #1;
    n_vec++; if ({dr1, dr4} !== 2'b01) begin n_err++;
      $display("FAIL t5_rdy_first got=%b exp=01", {dr1, dr4}); end
    @(negedge clk); v4 = 1'b0; #1;
    n_vec++; if ({dv1, dd1} !== e1(1'b0, LA)) begin n_err++;
      $display("FAIL t5_n1_beat0 got=%h exp=%h", {dv1, dd1}, e1(1'b0, LA)); end
    n_vec++; if ({dv4, dd4} !== exp4) begin n_err++;
      $display("FAIL t5_n4_beat got=%h exp=%h", {dv4, dd4}, exp4); end
    n_vec++; if (dr1 !== 1'b0) begin n_err++;
      $display("FAIL t5_n1_rdy1 got=%b exp=0", dr1); end
    @(negedge clk); #1;
    n_vec++; if ({dv1, dd1} !== e1(1'b0, LB)) begin n_err++;
      $display("FAIL t5_n1_beat1 got=%h exp=%h", {dv1, dd1}, e1(1'b0, LB)); end
    n_vec++; if (dr1 !== 1'b1) begin n_err++;
      $display("FAIL t5_n1_rdy2 got=%b exp=1", dr1); end
    @(negedge clk); v1 = 1'b0; #1;
    n_vec++; if ({dv1, dd1} !== e1(1'b1, LC)) begin n_err++;
      $display("FAIL t5_n1_beat2 got=%h exp=%h", {dv1, dd1}, e1(1'b1, LC)); end
    n_vec++; if (dv4 !== 1'b0) begin n_err++;
      $display("FAIL t5_n4_drain got=%b exp=0", dv4); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word;
    @(negedge clk); set_word(3'd4, LD, LC, LB, LA); din_valid = 1'b1; dout_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b0, 2'd2, LB, LA)) begin n_err++;
      $display("FAIL t6_pre_beat got=%h exp=%h", {dout_valid, dout_data}, e2(1'b0, 2'd2, LB, LA)); end
    rst_n = 1'b0; #1;
    n_vec++; if ({dout_valid, dout_data} !== 36'h0) begin n_err++;
      $display("FAIL t6_async_drop got=%h exp=0", {dout_valid, dout_data}); end
    n_vec++; if (din_ready !== 1'b0) begin n_err++;
      $display("FAIL t6_rst_rdy got=%b exp=0", din_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_vec++; if (din_ready !== 1'b0) begin n_err++;
      $display("FAIL t6_restart_rdy got=%b exp=0", din_ready); end
    @(negedge clk); #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b0, 2'd2, LB, LA)) begin n_err++;
      $display("FAIL t6_beat0 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b0, 2'd2, LB, LA)); end
    @(negedge clk); din_valid = 1'b0; #1;
    n_vec++; if ({dout_valid, dout_data} !== e2(1'b1, 2'd2, LD, LC)) begin n_err++;
      $display("FAIL t6_beat1 got=%h exp=%h", {dout_valid, dout_data}, e2(1'b1, 2'd2, LD, LC)); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_word();
    test_clamp();
    test_out_widths();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
